// File: rtl/riscv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : riscv_pkg                                                  |
// | Description : Shared register-file sizing constants and small helpers    |
// |               used by the rename allocation / free logic.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package riscv_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PREG_W        = 6;

  // Architectural IDs (0..NUM_ARCH_REGS-1) are never returned to the free list.
  function automatic logic is_freeable(input logic [PREG_W-1:0] phys);
    return phys >= PREG_W'(NUM_ARCH_REGS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/preg_alloc_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin arbiter with a registered        |
// |               priority pointer that advances past each granted winner.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] c_last = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_winner;
  logic             w_found;

  // Scan requesters starting at the priority pointer; first one asserted wins.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    grant    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = (int'(r_ptr) + off) % NUM_REQ;
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = PTR_W'(idx);
      end
    end
    if (enable && w_found) begin
      grant[w_winner] = 1'b1;
    end
  end

  // Pointer moves to the requester after the winner, only when a grant issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (enable && w_found) begin
      r_ptr <= (w_winner == c_last) ? '0 : w_winner + PTR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/preg_alloc_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : preg_alloc_arbiter                                         |
// | Description : Shares a single-allocate free list among rename            |
// |               requesters (round-robin, zero latency) and stages commit   |
// |               frees through a small FIFO draining one ID per cycle.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module preg_alloc_arbiter
  import riscv_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FREE_Q_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req,
  output logic [NUM_REQ-1:0]                grant,
  output logic [PREG_W-1:0]                 grant_phys,
  input  logic                              flush,
  output logic                              fl_alloc_req,
  input  logic [PREG_W-1:0]                 fl_alloc_phys,
  input  logic                              fl_alloc_valid,
  input  logic [1:0]                        cfree_en,
  input  logic [PREG_W-1:0]                 cfree_phys0,
  input  logic [PREG_W-1:0]                 cfree_phys1,
  output logic                              free_ready,
  output logic                              fl_free_en,
  output logic [PREG_W-1:0]                 fl_free_phys,
  output logic [$clog2(FREE_Q_DEPTH):0]     free_q_count,
  output logic                              overflow_err,
  output logic [15:0]                       alloc_stall_cnt
);

  localparam int IDX_W = $clog2(FREE_Q_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // ---------------------------------------------------------------- alloc ---
  logic w_alloc_en;
  logic w_stall;

  assign w_alloc_en   = fl_alloc_valid && !flush;
  assign w_stall      = (|req) && !fl_alloc_valid && !flush;
  assign fl_alloc_req = |grant;
  assign grant_phys   = fl_alloc_phys;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .enable (w_alloc_en),
    .grant  (grant)
  );

  logic [15:0] r_stall_cnt;

  // Count cycles a requester waited on an empty free list; stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign alloc_stall_cnt = r_stall_cnt;

  // ----------------------------------------------------------------- free ---
  logic [PREG_W-1:0] r_mem [FREE_Q_DEPTH];
  logic [IDX_W-1:0]  r_head;
  logic [IDX_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_v0;
  logic              w_v1;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_deq;
  logic [CNT_W-1:0]  w_space;
  logic [CNT_W-1:0]  w_n_enq;
  logic [IDX_W-1:0]  w_tail1;

  // Space is judged against the pre-dequeue occupancy, so a same-cycle pop
  // never makes room for an incoming free; port 0 claims space first.
  always_comb begin
    w_v0    = cfree_en[0] && is_freeable(cfree_phys0);
    w_v1    = cfree_en[1] && is_freeable(cfree_phys1);
    w_space = CNT_W'(FREE_Q_DEPTH) - r_count;
    w_acc0  = w_v0 && (w_space != '0);
    w_acc1  = w_v1 && (w_space >= (w_acc0 ? CNT_W'(2) : CNT_W'(1)));
    w_deq   = (r_count != '0);
    w_n_enq = CNT_W'(w_acc0) + CNT_W'(w_acc1);
    w_tail1 = w_acc0 ? (r_tail + IDX_W'(1)) : r_tail;
  end

  // Storage array carries no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (w_acc0) begin
      r_mem[r_tail] <= cfree_phys0;
    end
    if (w_acc1) begin
      r_mem[w_tail1] <= cfree_phys1;
    end
  end

  // Pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tail  <= r_tail + IDX_W'(w_n_enq);
      r_count <= r_count + w_n_enq - CNT_W'(w_deq);
      if (w_deq) begin
        r_head <= r_head + IDX_W'(1);
      end
      if ((w_v0 && !w_acc0) || (w_v1 && !w_acc1)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign fl_free_en   = w_deq;
  assign fl_free_phys = w_deq ? r_mem[r_head] : '0;
  assign free_q_count = r_count;
  assign free_ready   = (r_count <= CNT_W'(FREE_Q_DEPTH - 2));
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire
